// File: rtl/universal_shift_register_burst.sv
// Universal shift register with rotate/ASR/clear modes and multi-step bursts on a valid/ready port.
// Optional registered even parity output q_par when USR_PARITY_EN is defined.
module universal_shift_register_burst #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    mode,
  input  logic [CW-1:0] amt,
  input  logic [N-1:0]  pin,
  input  logic          RSin,
  input  logic          LSin,
  output logic [N-1:0]  q,
  output logic          so,
  output logic          busy,
  output logic          done
`ifdef USR_PARITY_EN
  ,
  output logic          q_par
`endif
);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_SHR   = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_LOAD  = 3'b011;
  localparam logic [2:0] M_ROR   = 3'b100;
  localparam logic [2:0] M_ROL   = 3'b101;
  localparam logic [2:0] M_ASR   = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_nxt;
  logic [2:0]    op;
  logic [CW-1:0] count, count_nxt;
  logic [N-1:0]  q_nxt, step_q;
  logic          so_nxt, step_so, done_nxt;
  logic          accept, do_step;
  logic [2:0]    step_mode;

  function automatic logic is_shift(input logic [2:0] m);
    return (m == M_SHR) || (m == M_SHL) || (m == M_ROR) || (m == M_ROL) || (m == M_ASR);
  endfunction

  assign accept    = cmd_valid && cmd_ready;
  // The first step happens on the acceptance edge, so it uses the live mode, later steps the latched one.
  assign step_mode = accept ? mode : op;
  assign do_step   = (accept && is_shift(mode) && (amt != '0)) || (state == SHIFT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_shift(mode) && (amt > CW'(1))) state_nxt = SHIFT;
      SHIFT:   if (count == CW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = (state == SHIFT);
    cmd_ready = (state == IDLE);
  end

  // Single-step datapath
  always_comb begin
    step_q  = q;
    step_so = so;
    case (step_mode)
      M_SHR: begin step_q = {RSin, q[N-1:1]};     step_so = q[0];   end
      M_SHL: begin step_q = {q[N-2:0], LSin};     step_so = q[N-1]; end
      M_ROR: begin step_q = {q[0], q[N-1:1]};     step_so = q[0];   end
      M_ROL: begin step_q = {q[N-2:0], q[N-1]};   step_so = q[N-1]; end
      M_ASR: begin step_q = {q[N-1], q[N-1:1]};   step_so = q[0];   end
      default: ;
    endcase
  end

  always_comb begin
    q_nxt     = q;
    so_nxt    = so;
    count_nxt = count;
    done_nxt  = 1'b0;
    if (do_step) begin
      q_nxt  = step_q;
      so_nxt = step_so;
    end else if (accept && mode == M_LOAD) begin
      q_nxt = pin;
    end else if (accept && mode == M_CLEAR) begin
      q_nxt = '0;
    end
    if (accept) begin
      done_nxt = !is_shift(mode) || (amt <= CW'(1));
      if (do_step) count_nxt = amt - 1'b1;
    end else if (state == SHIFT) begin
      done_nxt  = (count == CW'(1));
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      so    <= 1'b0;
      done  <= 1'b0;
      count <= '0;
      op    <= M_HOLD;
    end else begin
      q     <= q_nxt;
      so    <= so_nxt;
      done  <= done_nxt;
      count <= count_nxt;
      if (accept) op <= mode;
    end
  end

`ifdef USR_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_par <= 1'b0;
    else     q_par <= ^q_nxt;
  end
`endif

endmodule

// File: tb/tb_universal_shift_register_burst.sv
// Directed bench for universal_shift_register_burst with an arithmetic reference model
// compared every cycle, plus literal expectations from hand-worked vectors.
module tb_universal_shift_register_burst;
  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [2:0] mode;
  logic [3:0] amt;
  logic [7:0] pin;
  logic       RSin, LSin;
  logic [7:0] q;
  logic       so, busy, done;
`ifdef USR_PARITY_EN
  logic       q_par;
`endif

  int checks = 0;
  int failures = 0;

  universal_shift_register_burst #(.N(8), .CW(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .mode(mode), .amt(amt), .pin(pin), .RSin(RSin), .LSin(LSin),
    .q(q), .so(so), .busy(busy), .done(done)
`ifdef USR_PARITY_EN
    , .q_par(q_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining-step counter plus arithmetic shifts
  logic [7:0] mq = 8'h00;
  logic       mso = 1'b0;
  logic       mdone = 1'b0;
  int         mrem = 0;
  logic [2:0] mop = 3'd0;

  function automatic logic [8:0] mstep(input logic [2:0] m, input logic [7:0] v,
                                       input logic r, input logic l);
    logic [7:0] nv;
    logic       o;
    nv = v; o = 1'b0;
    case (m)
      3'd1: begin nv = (v >> 1) | (r ? 8'h80 : 8'h00); o = v[0]; end
      3'd2: begin nv = (v << 1) | {7'd0, l};            o = v[7]; end
      3'd4: begin nv = (v >> 1) | (v << 7);             o = v[0]; end
      3'd5: begin nv = (v << 1) | (v >> 7);             o = v[7]; end
      3'd6: begin nv = 8'($signed(v) >>> 1);            o = v[0]; end
      default: ;
    endcase
    return {o, nv};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq <= 8'h00; mso <= 1'b0; mdone <= 1'b0; mrem <= 0;
    end else if (mrem == 0 && cmd_valid) begin
      mdone <= 1'b1;
      case (mode)
        3'd0: ;
        3'd3: mq <= pin;
        3'd7: mq <= 8'h00;
        default: if (amt != 0) begin
          {mso, mq} <= mstep(mode, mq, RSin, LSin);
          mrem      <= int'(amt) - 1;
          mop       <= mode;
          mdone     <= (amt == 4'd1);
        end
      endcase
    end else if (mrem > 0) begin
      {mso, mq} <= mstep(mop, mq, RSin, LSin);
      mrem      <= mrem - 1;
      mdone     <= (mrem == 1);
    end else begin
      mdone <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("q", 32'(q), 32'(mq));
    chk("so", 32'(so), 32'(mso));
    chk("busy", 32'(busy), 32'(mrem != 0));
    chk("cmd_ready", 32'(cmd_ready), 32'(mrem == 0));
    chk("done", 32'(done), 32'(mdone));
`ifdef USR_PARITY_EN
    chk("q_par", 32'(q_par), 32'(^mq));
`endif
  end

  // Called at a negedge; command is accepted on the following posedge.
  task automatic send(input logic [2:0] m, input logic [3:0] a, input logic [7:0] p,
                      input logic r, input logic l);
    cmd_valid = 1'b1; mode = m; amt = a; pin = p; RSin = r; LSin = l;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) break;
      @(negedge clk);
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; mode = 3'd0; amt = 4'd0; pin = 8'h00; RSin = 1'b0; LSin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_so", 32'(so), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // LOAD
    send(3'd3, 4'd0, 8'hA5, 1'b0, 1'b0); wait_done();
    chk("load_q", 32'(q), 32'hA5);
    chk("load_busy", 32'(busy), 32'd0);
    chk("load_so", 32'(so), 32'd0);
`ifdef USR_PARITY_EN
    chk("load_par", 32'(q_par), 32'd0);
`endif

    // SHR x3 with RSin=1
    send(3'd1, 4'd3, 8'h00, 1'b1, 1'b0); wait_done();
    chk("shr_q", 32'(q), 32'hF4);
    chk("shr_so", 32'(so), 32'd1);

    // ROL 8 wraps, ROL 9 rotates by one
    send(3'd3, 4'd0, 8'h3C, 1'b0, 1'b0); wait_done();
    send(3'd5, 4'd8, 8'h00, 1'b0, 1'b0); wait_done();
    chk("rol8_q", 32'(q), 32'h3C);
    send(3'd3, 4'd0, 8'h3C, 1'b0, 1'b0); wait_done();
    send(3'd5, 4'd9, 8'h00, 1'b0, 1'b0); wait_done();
    chk("rol9_q", 32'(q), 32'h78);
    chk("rol9_so", 32'(so), 32'd0);

    // ASR then CLEAR
    send(3'd3, 4'd0, 8'h80, 1'b0, 1'b0); wait_done();
    send(3'd6, 4'd2, 8'h00, 1'b0, 1'b0); wait_done();
    chk("asr_q", 32'(q), 32'hE0);
    chk("asr_so", 32'(so), 32'd0);
    send(3'd7, 4'd0, 8'h00, 1'b0, 1'b0); wait_done();
    chk("clr_q", 32'(q), 32'h00);
    chk("clr_done", 32'(done), 32'd1);

    // LOAD held pending during SHL burst, accepted in the done cycle
    send(3'd3, 4'd0, 8'h01, 1'b0, 1'b0); wait_done();
    cmd_valid = 1'b1; mode = 3'd2; amt = 4'd5; LSin = 1'b0;
    @(negedge clk);
    mode = 3'd3; pin = 8'hFF;
    chk("b2b_ready", 32'(cmd_ready), 32'd0);
    wait_done();
    chk("shl_q", 32'(q), 32'h20);
    @(negedge clk);
    chk("b2b_q", 32'(q), 32'hFF);
    chk("b2b_done", 32'(done), 32'd1);
    cmd_valid = 1'b0;
    @(negedge clk);

    // Async reset mid-burst
    send(3'd3, 4'd0, 8'hA5, 1'b0, 1'b0); wait_done();
    send(3'd1, 4'd6, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_q", 32'(q), 32'h00);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_so", 32'(so), 32'd0);
    chk("arst_ready", 32'(cmd_ready), 32'd1);
`ifdef USR_PARITY_EN
    chk("arst_par", 32'(q_par), 32'd0);
`endif
    @(negedge clk);
    chk("arst_nodone", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_done", 32'(done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/universal_shift_register_burst.md
Name: universal_shift_register_burst

Overview:
- Parametrised successor to the 4-bit universal shift register; keeps the hold, shift-right, shift-left and parallel-load modes with their original 2-bit codes.
- Adds rotate, arithmetic-shift-right and clear modes, plus multi-step burst shifts of a programmable count.
- Commands arrive on a valid/ready handshake; serial-out, busy and done status are provided.
- Used as a datapath shifter/serialiser feeding serial links and bit-manipulation blocks.

Parameters:
- N, 8, register width in bits; must be at least 2.
- CW, 4, width of the burst shift count `amt`; maximum burst is 2^CW-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command; equals ~busy.
- mode  input  3  operation code: 000 HOLD, 001 SHR, 010 SHL, 011 LOAD, 100 ROR, 101 ROL, 110 ASR, 111 CLEAR.
- amt  input  CW  number of single-bit steps for shift and rotate modes.
- pin  input  N  parallel load data.
- RSin  input  1  serial input entering at the MSB on SHR.
- LSin  input  1  serial input entering at the LSB on SHL.
- q  output  N  register contents.
- so  output  1  last bit shifted or rotated out.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse marking command completion.

Behaviour:
- Reset while rst is high: q=0, so=0, busy=0, done=0, internal count=0, state IDLE. Reset mid-burst aborts the burst with no done pulse.
- States:
  - IDLE: busy=0, cmd_ready=1.
  - SHIFT: busy=1, cmd_ready=0.
- Accept: a command is accepted on a rising edge when cmd_valid && cmd_ready. mode and amt are latched at acceptance; changes to them during SHIFT are ignored. cmd_valid in SHIFT is ignored and not queued.
- LOAD, CLEAR and HOLD:
  - On the acceptance edge, LOAD sets q<=pin, CLEAR sets q<=0, HOLD leaves q unchanged.
  - done<=1 on the same edge; state stays IDLE; so is unchanged.
- Shift/rotate with amt==0: treated as HOLD (done pulse, q and so unchanged).
- Shift/rotate with amt=k≥1:
  - The first step is applied on the acceptance edge, with count<=k-1.
  - If k==1: done<=1, stay IDLE.
  - Otherwise enter SHIFT and apply one step per edge, decrementing count.
  - On the edge where count==1, apply the final step, set done<=1 and return to IDLE.
  - q holds the final value k edges after acceptance, inclusive; busy is high for k-1 cycles.
- Step definitions:
  - SHR: q<={RSin,q[N-1:1]}, so<=q[0].
  - SHL: q<={q[N-2:0],LSin}, so<=q[N-1].
  - ROR: q<={q[0],q[N-1:1]}, so<=q[0].
  - ROL: q<={q[N-2:0],q[N-1]}, so<=q[N-1].
  - ASR: q<={q[N-1],q[N-1:1]}, so<=q[0].
  - RSin and LSin are sampled live on every step edge, not latched at acceptance.
- Bursts longer than N are legal: SHR/SHL/ASR saturate to fill patterns; rotates wrap modulo N.
- done is high for exactly one cycle, the first cycle q shows the final value.
- Back-to-back: a new command may be accepted in the cycle done is high; the next done can follow immediately.

Optional Feature:
- Macro: USR_PARITY_EN.
- When defined: adds output port q_par (1 bit), a registered even parity of q updated on the same edge as q, so q_par always equals ^q as seen on the outputs. Reset value 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, then LOAD pin=8'hA5 -> q=8'hA5 the next cycle; done high 1 cycle; busy stays 0; so=0.
2. From 8'hA5, SHR amt=3 with RSin=1 -> q=8'hD2, then 8'hE9, then 8'hF4; busy high 2 cycles; done with q=8'hF4; so=1.
3. From 8'h3C, ROL amt=8 -> q=8'h3C at done. Then ROL amt=9 from 8'h3C -> q=8'h78, so=0.
4. From 8'h80, ASR amt=2 -> q=8'hE0, so=0. Then CLEAR -> q=8'h00 with a done pulse.
5. During an SHL amt=5 burst, hold cmd_valid high with LOAD pin=8'hFF -> cmd_ready=0 and q is unaffected; the LOAD is accepted in the done cycle and q=8'hFF the following cycle.
6. Assert rst asynchronously mid-burst (between edges) -> q=0, busy=0, so=0 immediately; no done pulse. With USR_PARITY_EN defined, q_par=0 after reset and q_par=0 after loading 8'hA5.
